reg_writeback: RTL and testbench
================================

Name: reg_writeback

Overview:
- Write-side sequencer for the 16x16 register file.
- Accepts result packets from the execute/memory stages over a valid/ready handshake and buffers them in a small FIFO.
- Drains one packet per cycle onto the register file write ports: regDst/regDstData/wr, plus regR15Data/wrR15 for the high-product/remainder port.
- Exports a per-register pending scoreboard and two forwarding lookups so decode can stall or bypass before the data reaches the file.

Parameters:
DEPTH, 2, FIFO entries (power of 2, >=2)
DW, 16, data width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
in_valid  in  1  producer has a packet
in_ready  out  1  FIFO can accept (count < DEPTH)
in_dst  in  4  destination register
in_data  in  DW  destination data
in_r15_data  in  DW  data for R15 port
in_wr  in  1  packet writes in_dst
in_wr15  in  1  packet writes R15 via dedicated port
hold  in  1  freeze drain (register file write port unavailable)
regDst  out  4  register file write address
regDstData  out  DW  register file write data
regR15Data  out  DW  R15 port write data
wr  out  1  write strobe, destination port
wrR15  out  1  write strobe, R15 port
pending  out  16  bit i = a write to Ri is buffered or on the output stage
qR1  in  4  forwarding query 1
qR2  in  4  forwarding query 2
fwdHit1  out  1  query 1 matches a buffered write
fwdData1  out  DW  youngest matching value, query 1
fwdHit2  out  1  query 2 matches a buffered write
fwdData2  out  DW  youngest matching value, query 2

Behaviour:
- Reset (rst=0, async): FIFO count/pointers=0; regDst=0, regDstData=0, regR15Data=0, wr=0, wrR15=0. This forces pending=0, fwdHit*=0, fwdData*=0, in_ready=1. In-flight packets are discarded. Reset release is taken synchronously at the next edge.
- Accept: at posedge when in_valid & in_ready.
  - Packets with in_wr=0 and in_wr15=0 are accepted and dropped (not enqueued).
  - in_ready depends only on count, never on same-cycle pop.
- Conflict normalisation: in_wr=1 & in_wr15=1 & in_dst=15 → R15 port wins. The entry is stored with wr cleared and only in_r15_data is written.
- Output stage is registered. Each posedge with hold=0 and FIFO non-empty:
  - Pop head into the output registers.
  - wr/wrR15 take the head's flags for exactly one cycle.
  - With hold=0 and FIFO empty, wr=wrR15=0 and the address/data registers hold their last values.
- hold=1: no pop; wr and wrR15 forced 0 at the next edge; address/data unchanged. Pushes continue until full.
- Latency:
  - Packet accepted at edge N into an empty FIFO pops at edge N+1; wr is high during cycle N+1 to N+2.
  - The register file captures the data at edge N+2.
  - Throughput is 1 packet/cycle; simultaneous push and pop is allowed whenever count < DEPTH.
- Full:
  - count=DEPTH → in_ready=0.
  - A pop in that cycle does not re-enable ready until the following cycle.
- pending (combinational) covers valid FIFO entries plus the output stage while wr/wrR15 is high:
  - OR of onehot(dst) for entries with wr.
  - OR of bit 15 for entries with wr15.
- Forwarding (combinational), per query q:
  - Scan from youngest FIFO entry to oldest, then the output stage.
  - First match supplies the data: dst==q & wr → data; q==15 & wr15 → r15_data.
  - Within one entry the R15 port takes precedence.
  - No match → hit=0, data=0.
- FIFO pointers wrap modulo DEPTH; count is DEPTH-bit safe (0..DEPTH).

Test Plan:
- Reset: assert rst=0 mid-drain with 2 entries queued → wr=wrR15=0, pending=16'h0000, in_ready=1 immediately, without waiting for a clock edge.
- Single write: push dst=1, data=16'hCCCC, in_wr=1 at edge N → wr=1, regDst=1, regDstData=16'hCCCC during cycle N+1 only; pending[1]=1 from N to N+2.
- Dual port: push dst=2, data=16'hF0F0, r15_data=16'h0F0F, wr=1, wr15=1 → wr=wrR15=1 in the same cycle; pending=16'h8004; qR1=15 returns fwdHit1=1, fwdData1=16'h0F0F.
- Conflict: push dst=15, data=16'hAAAA, r15_data=16'hBBBB, both flags set → wr=0, wrR15=1, regR15Data=16'hBBBB.
- Backpressure: hold=1, push 3 packets → in_ready=0 after 2 accepted, third held by producer. Release hold → three wr pulses in order on consecutive cycles.
- Forward youngest: with hold=1, queue dst=3 data=16'h1111 then dst=3 data=16'h2222 → qR2=3 gives fwdHit2=1, fwdData2=16'h2222. After both drain → fwdHit2=0.

Source files
------------

// File: rtl/reg_writeback.sv
// Write-side sequencer for the 16x16 register file: buffers result packets in a
// small FIFO, drains one per cycle to the write ports, and exposes pending/forwarding.
module reg_writeback #(
    parameter int DEPTH = 2,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_dst,
    input  logic [DW-1:0] in_data,
    input  logic [DW-1:0] in_r15_data,
    input  logic          in_wr,
    input  logic          in_wr15,
    input  logic          hold,
    output logic [3:0]    regDst,
    output logic [DW-1:0] regDstData,
    output logic [DW-1:0] regR15Data,
    output logic          wr,
    output logic          wrR15,
    output logic [15:0]   pending,
    input  logic [3:0]    qR1,
    input  logic [3:0]    qR2,
    output logic          fwdHit1,
    output logic [DW-1:0] fwdData1,
    output logic          fwdHit2,
    output logic [DW-1:0] fwdData2
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic          wr;
        logic          wr15;
        logic [3:0]    dst;
        logic [DW-1:0] data;
        logic [DW-1:0] r15;
    } entry_t;

    // Handshake: a packet transfers on a rising edge where in_valid and in_ready
    // are both high; in_ready is a function of the registered count only.
    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    entry_t        out_q;
    entry_t        in_entry;
    entry_t        head;
    logic          push;
    logic          pop;

    assign in_ready = (count_q != FULL_CNT);
    assign push     = in_valid & in_ready & (in_wr | in_wr15);
    assign pop      = ~hold & (count_q != '0);
    assign head     = mem_q[rd_ptr_q];
    assign count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);

    // A dual write aimed at R15 collapses onto the dedicated R15 port.
    assign in_entry = '{wr:   in_wr & ~(in_wr15 & (in_dst == 4'd15)),
                        wr15: in_wr15,
                        dst:  in_dst,
                        data: in_data,
                        r15:  in_r15_data};

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            out_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                out_q    <= head;
            end else begin
                out_q.wr   <= 1'b0;
                out_q.wr15 <= 1'b0;
            end
            count_q <= count_d;
        end
    end

    assign regDst     = out_q.dst;
    assign regDstData = out_q.data;
    assign regR15Data = out_q.r15;
    assign wr         = out_q.wr;
    assign wrR15      = out_q.wr15;

    function automatic logic [DW:0] match(input entry_t e, input logic [3:0] q);
        logic [DW:0] r;
        r = '0;
        if (e.wr15 && (q == 4'd15)) begin
            r = {1'b1, e.r15};
        end else if (e.wr && (e.dst == q)) begin
            r = {1'b1, e.data};
        end
        return r;
    endfunction

    logic [15:0]   pend;
    logic [DW:0]   f1;
    logic [DW:0]   f2;
    logic [DW:0]   m1;
    logic [DW:0]   m2;
    logic [AW-1:0] idx;

    // Walk oldest to youngest so a younger match overwrites an older one.
    always_comb begin
        pend = '0;
        idx  = rd_ptr_q;
        m1   = '0;
        m2   = '0;
        f1   = match(out_q, qR1);
        f2   = match(out_q, qR2);
        if (out_q.wr) pend[out_q.dst] = 1'b1;
        if (out_q.wr15) pend[15] = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + AW'(k);
            if ((AW+1)'(k) < count_q) begin
                if (mem_q[idx].wr) pend[mem_q[idx].dst] = 1'b1;
                if (mem_q[idx].wr15) pend[15] = 1'b1;
                m1 = match(mem_q[idx], qR1);
                m2 = match(mem_q[idx], qR2);
                if (m1[DW]) f1 = m1;
                if (m2[DW]) f2 = m2;
            end
        end
    end

    assign pending  = pend;
    assign fwdHit1  = f1[DW];
    assign fwdData1 = f1[DW-1:0];
    assign fwdHit2  = f2[DW];
    assign fwdData2 = f2[DW-1:0];

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: queue-based reference model of the FIFO and output
// stage, write-order scoreboard, directed scenarios followed by random traffic.
module tb_reg_writeback;
  localparam int DEPTH = 2;
  localparam int DW    = 16;

  typedef struct packed {
    logic          wr;
    logic          wr15;
    logic [3:0]    dst;
    logic [DW-1:0] data;
    logic [DW-1:0] r15;
  } pkt_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_dst = '0;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] in_r15_data = '0;
  logic          in_wr = 1'b0;
  logic          in_wr15 = 1'b0;
  logic          hold = 1'b0;
  logic [3:0]    regDst;
  logic [DW-1:0] regDstData;
  logic [DW-1:0] regR15Data;
  logic          wr;
  logic          wrR15;
  logic [15:0]   pending;
  logic [3:0]    qR1 = '0;
  logic [3:0]    qR2 = '0;
  logic          fwdHit1;
  logic [DW-1:0] fwdData1;
  logic          fwdHit2;
  logic [DW-1:0] fwdData2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [37:0] exp_q[$];
  pkt_t        mdl_f[$];
  pkt_t        mdl_out = '0;

  reg_writeback #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dst(in_dst), .in_data(in_data), .in_r15_data(in_r15_data),
    .in_wr(in_wr), .in_wr15(in_wr15), .hold(hold),
    .regDst(regDst), .regDstData(regDstData), .regR15Data(regR15Data),
    .wr(wr), .wrR15(wrR15), .pending(pending),
    .qR1(qR1), .qR2(qR2),
    .fwdHit1(fwdHit1), .fwdData1(fwdData1),
    .fwdHit2(fwdHit2), .fwdData2(fwdData2)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] mdl_pending();
    logic [15:0] p;
    p = '0;
    foreach (mdl_f[i]) begin
      if (mdl_f[i].wr) p[mdl_f[i].dst] = 1'b1;
      if (mdl_f[i].wr15) p[15] = 1'b1;
    end
    if (mdl_out.wr) p[mdl_out.dst] = 1'b1;
    if (mdl_out.wr15) p[15] = 1'b1;
    return p;
  endfunction

  function automatic logic [16:0] pkt_hit(input pkt_t p, input logic [3:0] q);
    if (p.wr15 && q == 4'd15) return {1'b1, p.r15};
    if (p.wr && p.dst == q) return {1'b1, p.data};
    return 17'h0;
  endfunction

  function automatic logic [16:0] mdl_fwd(input logic [3:0] q);
    logic [16:0] r;
    for (int i = mdl_f.size() - 1; i >= 0; i--) begin
      r = pkt_hit(mdl_f[i], q);
      if (r[16]) return r;
    end
    return pkt_hit(mdl_out, q);
  endfunction

  task automatic model_clear();
    mdl_f.delete();
    exp_q.delete();
    mdl_out = '0;
  endtask

  // Called right after each rising edge, while the inputs still hold their pre-edge values.
  task automatic model_edge();
    pkt_t p;
    bit   acc;
    bit   pop;
    if (!rst) begin
      model_clear();
      return;
    end
    acc = in_valid && (mdl_f.size() < DEPTH);
    pop = !hold && (mdl_f.size() > 0);
    mdl_out = '0;
    if (pop) mdl_out = mdl_f.pop_front();
    if (acc && (in_wr || in_wr15)) begin
      p.wr   = in_wr && !(in_wr15 && in_dst == 4'd15);
      p.wr15 = in_wr15;
      p.dst  = in_dst;
      p.data = in_data;
      p.r15  = in_r15_data;
      mdl_f.push_back(p);
      exp_q.push_back(p);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit h);
    hold = h;
    qR1 = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
    qR2 = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // hmode: 0 = hold low, 1 = hold high, 2 = hold randomly high 1 cycle in 4
  task automatic send(input logic [3:0] d, input logic [15:0] dat, input logic [15:0] r15,
                      input bit w, input bit w15, input int hmode);
    bit got;
    bit h;
    got = 1'b0;
    in_valid = 1'b1;
    in_dst = d;
    in_data = dat;
    in_r15_data = r15;
    in_wr = w;
    in_wr15 = w15;
    for (int t = 0; t < 40 && !got; t++) begin
      h = (hmode == 1) || (hmode == 2 && $urandom_range(0, 3) == 0);
      got = in_ready;
      cycle(h);
    end
    in_valid = 1'b0;
    if (!got) chk("send_timeout", 32'(got), 32'd1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [16:0] f1;
    logic [16:0] f2;
    pkt_t        e;
    f1 = mdl_fwd(qR1);
    f2 = mdl_fwd(qR2);
    chk("in_ready", 32'(in_ready), 32'(mdl_f.size() < DEPTH));
    chk("pending", 32'(pending), 32'(mdl_pending()));
    chk("fwd1", 32'({fwdHit1, fwdData1}), 32'(f1));
    chk("fwd2", 32'({fwdHit2, fwdData2}), 32'(f2));
    chk("strobes", 32'({wr, wrR15}), 32'({mdl_out.wr, mdl_out.wr15}));
    if (rst && (wr || wrR15)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'({wr, wrR15}), 32'd0);
      end else begin
        e = pkt_t'(exp_q.pop_front());
        chk("sb_flags", 32'({wr, wrR15}), 32'({e.wr, e.wr15}));
        if (e.wr) begin
          chk("sb_dst", 32'(regDst), 32'(e.dst));
          chk("sb_data", 32'(regDstData), 32'(e.data));
        end
        if (e.wr15) chk("sb_r15", 32'(regR15Data), 32'(e.r15));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regDst", 32'(regDst), 32'd0);
    chk("rst_regDstData", 32'(regDstData), 32'd0);
    chk("rst_regR15Data", 32'(regR15Data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b1;
    cycle(0);

    // single write
    send(4'd1, 16'hCCCC, 16'h0, 1'b1, 1'b0, 0);
    chk("sw_pend_N", 32'(pending[1]), 32'd1);
    chk("sw_wr_N", 32'(wr), 32'd0);
    cycle(0);
    chk("sw_wr_N1", 32'(wr), 32'd1);
    chk("sw_dst", 32'(regDst), 32'd1);
    chk("sw_data", 32'(regDstData), 32'hCCCC);
    chk("sw_pend_N1", 32'(pending[1]), 32'd1);
    cycle(0);
    chk("sw_wr_N2", 32'(wr), 32'd0);
    chk("sw_pend_N2", 32'(pending[1]), 32'd0);

    // dual port
    send(4'd2, 16'hF0F0, 16'h0F0F, 1'b1, 1'b1, 0);
    qR1 = 4'd15;
    #1;
    chk("dual_pending", 32'(pending), 32'h8004);
    chk("dual_hit1", 32'(fwdHit1), 32'd1);
    chk("dual_data1", 32'(fwdData1), 32'h0F0F);
    cycle(0);
    chk("dual_strobes", 32'({wr, wrR15}), 32'b11);
    cycle(0);

    // conflict on R15
    send(4'd15, 16'hAAAA, 16'hBBBB, 1'b1, 1'b1, 0);
    cycle(0);
    chk("conf_wr", 32'(wr), 32'd0);
    chk("conf_wrR15", 32'(wrR15), 32'd1);
    chk("conf_r15", 32'(regR15Data), 32'hBBBB);
    cycle(0);

    // backpressure
    send(4'd4, 16'h0444, 16'h0, 1'b1, 1'b0, 1);
    send(4'd5, 16'h0555, 16'h0, 1'b1, 1'b0, 1);
    in_valid = 1'b1;
    in_dst = 4'd6;
    in_data = 16'h0666;
    in_wr = 1'b1;
    in_wr15 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready_low", 32'(in_ready), 32'd0);
      cycle(1);
    end
    cycle(0);
    chk("bp_wr0", 32'({wr, regDst}), 32'({1'b1, 4'd4}));
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    cycle(0);
    in_valid = 1'b0;
    chk("bp_wr1", 32'({wr, regDst}), 32'({1'b1, 4'd5}));
    cycle(0);
    chk("bp_wr2", 32'({wr, regDst}), 32'({1'b1, 4'd6}));
    cycle(0);

    // forward youngest
    send(4'd3, 16'h1111, 16'h0, 1'b1, 1'b0, 1);
    send(4'd3, 16'h2222, 16'h0, 1'b1, 1'b0, 1);
    qR2 = 4'd3;
    #1;
    chk("fy_hit", 32'(fwdHit2), 32'd1);
    chk("fy_data", 32'(fwdData2), 32'h2222);
    repeat (3) cycle(0);
    qR2 = 4'd3;
    #1;
    chk("fy_drained", 32'(fwdHit2), 32'd0);

    // asynchronous reset mid-drain
    send(4'd7, 16'h0777, 16'h0, 1'b1, 1'b0, 1);
    send(4'd8, 16'h0888, 16'h0, 1'b1, 1'b0, 1);
    cycle(0);
    #2;
    rst = 1'b0;
    model_clear();
    #1;
    chk("ar_wr", 32'({wr, wrR15}), 32'd0);
    chk("ar_pending", 32'(pending), 32'd0);
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    chk("ar_regDst", 32'(regDst), 32'd0);
    cycle(0);
    rst = 1'b1;
    cycle(0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) != 0) begin
        send(($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 3)),
             16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2);
      end else begin
        cycle($urandom_range(0, 3) == 0);
      end
    end

    // drain
    for (int i = 0; i < 12 && (exp_q.size() != 0 || mdl_f.size() != 0); i++) cycle(0);
    repeat (2) cycle(0);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
